// File: rtl/dmrs_all.sv
// DMRS symbol generator: one QPSK symbol per cycle from the latched Nsc table, then a held done level.
// Latency: symbol n appears one edge after start plus n; no backpressure, dmrs_en only gates start/exit.
module dmrs_all (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmrs_en,
  input  logic [3:0]  Nsc,
  output logic [31:0] real_part,
  output logic [31:0] img_part,
  output logic        dmrs_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [31:0] AMP_POS = 32'h0000_B505;
  localparam logic [31:0] AMP_NEG = 32'hFFFF_4AFB;

  localparam logic [1:0] TBL_N1  = 2'd0;
  localparam logic [1:0] TBL_N3  = 2'd1;
  localparam logic [1:0] TBL_N6  = 2'd2;
  localparam logic [1:0] TBL_N12 = 2'd3;

  // Two bits per symbol {re_neg, im_neg}, symbol 0 in the LSBs: +1=00, -1=01, +3=10, -3=11.
  localparam logic [23:0] PH_N12 = 24'b10_11_00_10_00_00_10_10_11_10_00_01;
  localparam logic [23:0] PH_N6  = 24'b00_00_00_00_00_00_11_10_00_00_00_00;
  localparam logic [23:0] PH_N3  = 24'b00_00_00_00_00_00_00_00_00_11_11_00;
  localparam logic [23:0] PH_N1  = 24'b0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  tbl_q, tbl_d;
  logic [31:0] real_q, real_d;
  logic [31:0] img_q, img_d;
  logic        done_q, done_d;

  logic [23:0] ph_vec;
  logic [1:0]  ph_code;
  logic [3:0]  last_idx;

  always_comb begin
    ph_vec   = PH_N1;
    last_idx = 4'd0;
    case (tbl_q)
      TBL_N3:  begin ph_vec = PH_N3;  last_idx = 4'd2;  end
      TBL_N6:  begin ph_vec = PH_N6;  last_idx = 4'd5;  end
      TBL_N12: begin ph_vec = PH_N12; last_idx = 4'd11; end
      default: begin ph_vec = PH_N1;  last_idx = 4'd0;  end
    endcase
    ph_code = ph_vec[{idx_q, 1'b0} +: 2];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tbl_d   = tbl_q;
    real_d  = 32'd0;
    img_d   = 32'd0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dmrs_en) begin
          idx_d   = 4'd0;
          state_d = S_GEN;
          case (Nsc)
            4'd1:    tbl_d = TBL_N1;
            4'd3:    tbl_d = TBL_N3;
            4'd6:    tbl_d = TBL_N6;
            4'd12:   tbl_d = TBL_N12;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_GEN: begin
        real_d = ph_code[1] ? AMP_NEG : AMP_POS;
        img_d  = ph_code[0] ? AMP_NEG : AMP_POS;
        if (idx_q == last_idx) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_DONE: begin
        // The first DONE edge always raises done, so a release during GEN still shows completion.
        if (!done_q) begin
          done_d = 1'b1;
        end else if (dmrs_en) begin
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      tbl_q   <= TBL_N1;
      real_q  <= 32'd0;
      img_q   <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tbl_q   <= tbl_d;
      real_q  <= real_d;
      img_q   <= img_d;
      done_q  <= done_d;
    end
  end

  assign real_part = real_q;
  assign img_part  = img_q;
  assign dmrs_done = done_q;

endmodule

// File: tb/tb_dmrs_all.sv
// Directed bench for dmrs_all: expected symbol lists written out by hand as sign pairs.
module tb_dmrs_all;

  localparam logic [31:0] A_POS = 32'h0000_B505;
  localparam logic [31:0] A_NEG = 32'hFFFF_4AFB;

  logic        clk;
  logic        reset;
  logic        dmrs_en;
  logic [3:0]  Nsc;
  logic [31:0] real_part;
  logic [31:0] img_part;
  logic        dmrs_done;

  int checks = 0;
  int errors = 0;

  // Sign pairs (+1 -> +A, -1 -> -A), one row per expected symbol.
  int exp12_re [12] = '{ 1,  1, -1, -1, -1, -1,  1,  1, -1,  1, -1, -1};
  int exp12_im [12] = '{-1,  1,  1, -1,  1,  1,  1,  1,  1,  1, -1,  1};
  int exp6_re  [6]  = '{ 1,  1,  1,  1, -1, -1};
  int exp6_im  [6]  = '{ 1,  1,  1,  1,  1, -1};
  int exp3_re  [3]  = '{ 1, -1, -1};
  int exp3_im  [3]  = '{ 1, -1, -1};

  dmrs_all dut (
    .clk       (clk),
    .reset     (reset),
    .dmrs_en   (dmrs_en),
    .Nsc       (Nsc),
    .real_part (real_part),
    .img_part  (img_part),
    .dmrs_done (dmrs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] amp(input int s);
    return (s > 0) ? A_POS : A_NEG;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic done_exp);
    chk({tag, " re"}, real_part, 32'd0);
    chk({tag, " im"}, img_part, 32'd0);
    chk({tag, " done"}, {31'd0, dmrs_done}, {31'd0, done_exp});
  endtask

  task automatic chk_sym(input string tag, input int re_s, input int im_s);
    chk({tag, " re"}, real_part, amp(re_s));
    chk({tag, " im"}, img_part, amp(im_s));
    chk({tag, " done"}, {31'd0, dmrs_done}, 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    dmrs_en = 1'b0;
    Nsc     = 4'd0;
    step();
    step();
    chk_idle("reset", 1'b0);

    // Nsc=12, enable held high throughout
    reset   = 1'b0;
    Nsc     = 4'd12;
    dmrs_en = 1'b1;
    step();
    chk_idle("n12 start", 1'b0);
    for (int n = 0; n < 12; n++) begin
      step();
      chk_sym($sformatf("n12 sym%0d", n), exp12_re[n], exp12_im[n]);
    end
    step();
    chk_idle("n12 done", 1'b1);
    step();
    chk_idle("n12 hold", 1'b1);
    dmrs_en = 1'b0;
    step();
    chk_idle("n12 release", 1'b0);

    // Nsc=3: done four edges after start
    Nsc     = 4'd3;
    dmrs_en = 1'b1;
    step();
    chk_idle("n3 start", 1'b0);
    for (int n = 0; n < 3; n++) begin
      step();
      chk_sym($sformatf("n3 sym%0d", n), exp3_re[n], exp3_im[n]);
    end
    step();
    chk_idle("n3 done", 1'b1);
    dmrs_en = 1'b0;
    step();
    chk_idle("n3 release", 1'b0);

    // Nsc=6 then Nsc=1 with enable dropped in between
    Nsc     = 4'd6;
    dmrs_en = 1'b1;
    step();
    chk_idle("n6 start", 1'b0);
    for (int n = 0; n < 6; n++) begin
      step();
      chk_sym($sformatf("n6 sym%0d", n), exp6_re[n], exp6_im[n]);
    end
    step();
    chk_idle("n6 done", 1'b1);
    dmrs_en = 1'b0;
    step();
    chk_idle("n6 release", 1'b0);
    step();
    chk_idle("idle stays", 1'b0);
    Nsc     = 4'd1;
    dmrs_en = 1'b1;
    step();
    chk_idle("n1 start", 1'b0);
    step();
    chk_sym("n1 sym0", 1, 1);
    step();
    chk_idle("n1 done", 1'b1);
    dmrs_en = 1'b0;
    step();
    chk_idle("n1 release", 1'b0);

    // Illegal Nsc=5: straight to done, no symbols
    Nsc     = 4'd5;
    dmrs_en = 1'b1;
    step();
    chk_idle("n5 start", 1'b0);
    step();
    chk_idle("n5 done", 1'b1);
    dmrs_en = 1'b0;
    step();
    chk_idle("n5 release", 1'b0);

    // Reset at the 5th sample of Nsc=12, enable still high -> restart from idx 0
    Nsc     = 4'd12;
    dmrs_en = 1'b1;
    step();
    for (int n = 0; n < 4; n++) begin
      step();
      chk_sym($sformatf("rst pre sym%0d", n), exp12_re[n], exp12_im[n]);
    end
    reset = 1'b1;
    step();
    chk_idle("rst mid", 1'b0);
    reset = 1'b0;
    step();
    chk_idle("rst restart", 1'b0);
    for (int n = 0; n < 3; n++) begin
      step();
      chk_sym($sformatf("rst post sym%0d", n), exp12_re[n], exp12_im[n]);
    end
    reset   = 1'b1;
    dmrs_en = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk_idle("rst clean", 1'b0);

    // Nsc 12->3 and enable dropped during GEN: full 12 still emitted
    Nsc     = 4'd12;
    dmrs_en = 1'b1;
    step();
    for (int n = 0; n < 12; n++) begin
      step();
      chk_sym($sformatf("chg sym%0d", n), exp12_re[n], exp12_im[n]);
      if (n == 1) begin
        Nsc     = 4'd3;
        dmrs_en = 1'b0;
      end
    end
    step();
    chk_idle("chg done", 1'b1);
    step();
    chk_idle("chg release", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmrs_all.md
DMRS_ALL -- requirements
Module: dmrs_all

Interface
REQ-001 SHALL provide port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL provide port: dmrs_en  input  1  level enable; a high level in IDLE starts one sequence.
REQ-004 SHALL provide port: Nsc  input  4  subcarrier count; legal values 1, 3, 6, 12.
REQ-005 SHALL provide port: real_part  output  32  signed two's-complement Q16.16 in-phase sample, registered.
REQ-006 SHALL provide port: img_part  output  32  signed two's-complement Q16.16 quadrature sample, registered.
REQ-007 SHALL provide port: dmrs_done  output  1  level high while the sequence is complete, registered.

Function
REQ-008 SHALL implement a 3-state FSM: IDLE, GEN, DONE.
REQ-009 SHALL, in IDLE with dmrs_en=1 at an edge, latch Nsc, clear the index to 0 and enter GEN; outputs stay 0 at that edge.
REQ-010 SHALL, in IDLE with dmrs_en=0, remain in IDLE with all outputs 0.
REQ-011 SHALL, in GEN at each edge, register symbol[idx] onto real_part/img_part, one symbol per cycle, in index order.
REQ-012 SHALL, in GEN at the edge emitting idx = N-1, enter DONE; otherwise increment idx.
REQ-013 SHALL, on the first edge in DONE, set real_part/img_part to 0 and dmrs_done to 1.
REQ-014 SHALL hold DONE, dmrs_done=1 and outputs 0 while dmrs_en=1; dmrs_en=0 in DONE returns to IDLE and clears dmrs_done on that edge.
REQ-015 SHALL ignore Nsc changes after latching; dmrs_en deassertion during GEN has no effect.
REQ-016 SHALL give latency: start edge k, symbol n visible after edge k+1+n, dmrs_done high after edge k+N+1.
REQ-017 SHALL map phase phi to the symbol exp(j*phi*pi/4): phi=+1 -> (+A,+A), -1 -> (+A,-A), +3 -> (-A,+A), -3 -> (-A,-A).
REQ-018 SHALL use A = 46341 (0x0000B505) and -A = 0xFFFF4AFB (Q16.16 of 1/sqrt2).
REQ-019 SHALL use the phase table for Nsc=12 (N=12): -1 1 3 -3 3 3 1 1 3 1 -3 3.
REQ-020 SHALL use the phase table for Nsc=6 (N=6): 1 1 1 1 3 -3.
REQ-021 SHALL use the phase table for Nsc=3 (N=3): 1 -3 -3.
REQ-022 SHALL emit a single symbol (+A,+A) for Nsc=1 (N=1).
REQ-023 SHALL, for any other Nsc value, go from IDLE directly to DONE with no symbols emitted; dmrs_done rises on the edge after the start edge.
REQ-024 SHALL emit nothing other than 0 or +/-A on either output.

Reset
REQ-025 SHALL, with reset=1 at an edge, force IDLE, idx=0, real_part=0, img_part=0 and dmrs_done=0, overriding all other inputs.
REQ-026 SHALL abort any sequence in progress on reset mid-GEN or mid-DONE; a new start requires dmrs_en high after reset is released.
REQ-027 SHALL, on the first edge after reset deasserts with dmrs_en already high, treat that edge as a start edge.

Verification
REQ-028 SHALL verify: reset pulse, then Nsc=12 with dmrs_en held high -> 12 samples (+A,-A),(+A,+A),(-A,+A),(-A,-A),(-A,+A),(-A,+A),(+A,+A),(+A,+A),(-A,+A),(+A,+A),(-A,-A),(-A,+A) on consecutive cycles, then dmrs_done=1 and outputs 0 held.
REQ-029 SHALL verify: Nsc=3 -> (+A,+A),(-A,-A),(-A,-A); dmrs_done rises 4 edges after the start edge.
REQ-030 SHALL verify: Nsc=6 then Nsc=1 runs, with dmrs_en dropped between them -> DONE returns to IDLE; second run emits a single (+A,+A).
REQ-031 SHALL verify: Nsc=5 -> no nonzero sample, dmrs_done=1 after the edge following the start edge.
REQ-032 SHALL verify: reset asserted at the 5th sample of Nsc=12 -> outputs 0, dmrs_done=0 next edge; the sequence restarts from idx 0 after reset is released.
REQ-033 SHALL verify: Nsc changed 12->3 during GEN -> the full 12-sample sequence still emitted.
